// File: rtl/apb_slave_ctrl.sv
// APB3/APB4 slave front-end: turns APB transfers into single-cycle register strobes.
// Adds fixed wait states, backend stall with saturating timeout, and address/alignment error reporting.
module apb_slave_ctrl #(
  parameter int                ADDR_W      = 12,
  parameter int                DATA_W      = 32,
  parameter int                WAIT_STATES = 0,
  parameter logic [ADDR_W-1:0] ADDR_MAX    = 'h03C,
  parameter bit                ALIGN_CHK   = 1'b1,
  parameter int                TIMEOUT     = 255,
  localparam int               STRB_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [STRB_W-1:0] pstrb,
  output logic              pready,
  output logic              pslverr,
  output logic [DATA_W-1:0] prdata,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic [STRB_W-1:0] reg_wstrb,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_busy
);

  localparam int                TO_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0]   TO_LIM     = TO_W'(TIMEOUT);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STRB_W - 1);
  localparam logic [3:0]        WAIT_INIT  = 4'(WAIT_STATES);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_wait_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_pwrite;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;

  logic w_latch;
  logic w_wait_dec;
  logic w_to_inc;
  logic w_err_nxt;
  logic w_to_lim;
  logic w_stall;
  logic w_active;
  logic w_done;
  logic w_to;

  assign w_err_nxt = (paddr > ADDR_MAX) | (ALIGN_CHK & ((paddr & ALIGN_MASK) != '0));
  assign w_to_lim  = (TIMEOUT != 0) && (r_to_cnt >= TO_LIM);
  assign w_stall   = reg_busy & ~r_err & ~w_to_lim;
  // Gating with rst_n keeps every strobe low during the reset cycle itself.
  assign w_active  = rst_n & (r_state == S_ACCESS) & psel & penable;
  assign w_done    = w_active & (r_wait_cnt == 4'd0) & ~w_stall;
  assign w_to      = w_done & reg_busy & ~r_err & w_to_lim;

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_wait_dec  = 1'b0;
    w_to_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (psel && !penable) begin
          w_latch     = 1'b1;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!psel) begin
          w_state_nxt = S_IDLE;
        end else if (!penable) begin
          w_latch = 1'b1;
        end else if (r_wait_cnt != 4'd0) begin
          w_wait_dec = 1'b1;
        end else if (w_stall) begin
          w_to_inc = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_to_cnt   <= '0;
      r_pwrite   <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_addr     <= paddr;
        r_wdata    <= pwdata;
        r_wstrb    <= pstrb;
        r_pwrite   <= pwrite;
        r_err      <= w_err_nxt;
        r_wait_cnt <= WAIT_INIT;
        r_to_cnt   <= '0;
      end else begin
        if (w_wait_dec) begin
          r_wait_cnt <= r_wait_cnt - 4'd1;
        end
        if (w_to_inc && (r_to_cnt != '1)) begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end
    end
  end

  assign pready    = w_done;
  assign pslverr   = w_done & (r_err | w_to);
  assign wr_en     = w_done & r_pwrite & ~r_err & ~w_to & (r_wstrb != '0);
  assign rd_en     = w_done & ~r_pwrite & ~r_err & ~w_to;
  assign prdata    = rd_en ? reg_rdata : '0;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_wstrb = r_wstrb;

endmodule

// File: tb/tb_apb_slave_ctrl.sv
// Bench for apb_slave_ctrl: four instances with different wait/timeout settings,
// each transfer's expected completion cycle and response derived from the transfer description.
module tb_apb_slave_ctrl;

  localparam int NI = 4;
  // instance: 0 defaults, 1 WAIT_STATES=3, 2 TIMEOUT=4, 3 WAIT_STATES=2 with TIMEOUT=0
  localparam logic [NI-1:0][7:0] WS_P = {8'd2, 8'd0, 8'd3, 8'd0};
  localparam logic [NI-1:0][7:0] TO_P = {8'd0, 8'd4, 8'd255, 8'd255};

  logic clk = 1'b0;
  logic rst_n;
  logic [NI-1:0]        psel, penable, pwrite, reg_busy, pready, pslverr, wr_en, rd_en;
  logic [NI-1:0][11:0]  paddr, reg_addr;
  logic [NI-1:0][31:0]  pwdata, prdata, reg_wdata, reg_rdata;
  logic [NI-1:0][3:0]   pstrb, reg_wstrb;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_wr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    apb_slave_ctrl #(
      .WAIT_STATES(int'(WS_P[g])),
      .TIMEOUT    (int'(TO_P[g]))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .psel     (psel[g]),
      .penable  (penable[g]),
      .pwrite   (pwrite[g]),
      .paddr    (paddr[g]),
      .pwdata   (pwdata[g]),
      .pstrb    (pstrb[g]),
      .pready   (pready[g]),
      .pslverr  (pslverr[g]),
      .prdata   (prdata[g]),
      .wr_en    (wr_en[g]),
      .rd_en    (rd_en[g]),
      .reg_addr (reg_addr[g]),
      .reg_wdata(reg_wdata[g]),
      .reg_wstrb(reg_wstrb[g]),
      .reg_rdata(reg_rdata[g]),
      .reg_busy (reg_busy[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [35:0] obs(input int k);
    return {pready[k], pslverr[k], wr_en[k], rd_en[k], prdata[k]};
  endfunction

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < NI; k++) chk(tag, 64'(obs(k)), 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    psel[k] = 1'b0;
    penable[k] = 1'b0;
    reg_busy[k] = 1'b0;
  endtask

  task automatic setup(input int k, input bit wr, input logic [11:0] a,
                       input logic [31:0] wd, input logic [3:0] st);
    psel[k] = 1'b1;
    penable[k] = 1'b0;
    pwrite[k] = wr;
    paddr[k] = a;
    pwdata[k] = wd;
    pstrb[k] = st;
    reg_busy[k] = 1'b0;
  endtask

  // One full transfer; reg_busy is high for the first busy_n access cycles.
  task automatic xfer(input int k, input bit wr, input logic [11:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] rd, input int busy_n);
    bit err, to, ok;
    int w, lim, b, s, dn;
    logic [35:0] expv;
    err = (a > 12'h03C) || (a[1:0] != 2'b00);
    w   = int'(WS_P[k]);
    lim = int'(TO_P[k]);
    b   = (busy_n > w) ? busy_n - w : 0;
    if (err) s = 0;
    else if (lim == 0 || b <= lim) s = b;
    else s = lim;
    to = !err && lim != 0 && b > lim;
    ok = !err && !to;
    dn = w + 1 + s;
    setup(k, wr, a, wd, st);
    reg_rdata[k] = rd;
    tick();
    penable[k] = 1'b1;
    for (int i = 1; i <= dn; i++) begin
      reg_busy[k] = (i <= busy_n);
      @(negedge clk);
      if (i == dn) begin
        expv = {1'b1, err | to, wr && ok && st != 4'd0, !wr && ok, (!wr && ok) ? rd : 32'd0};
        chk("xfer_done", 64'(obs(k)), 64'(expv));
        chk("xfer_addr", 64'(reg_addr[k]), 64'(a));
        chk("xfer_wdata", 64'(reg_wdata[k]), 64'(wd));
        chk("xfer_wstrb", 64'(reg_wstrb[k]), 64'(st));
        if (wr_en[k]) last_wr = cyc;
      end else begin
        chk("xfer_wait", 64'(obs(k)), 64'd0);
      end
      tick();
    end
    reg_busy[k] = 1'b0;
  endtask

  initial begin
    int t1;
    bit wr;
    int bn;
    rst_n = 1'b0;
    psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0;
    pstrb = '0; reg_rdata = '0; reg_busy = '0;
    repeat (2) begin
      @(negedge clk);
      chk_all_zero("reset");
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");
    chk("reset_addr", 64'(reg_addr[0]), 64'd0);
    chk("reset_wdata", 64'(reg_wdata[0]), 64'd0);
    tick();

    xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'd0, 0);
    idle(0); tick();
    xfer(1, 1'b0, 12'h004, 32'd0, 4'hF, 32'h12345678, 0);
    idle(1); tick();
    xfer(0, 1'b0, 12'h040, 32'd0, 4'hF, 32'hCAFEF00D, 0);
    xfer(0, 1'b0, 12'h006, 32'd0, 4'hF, 32'hCAFEF00D, 0);
    idle(0); tick();

    xfer(2, 1'b1, 12'h008, 32'h0000A5A5, 4'hF, 32'd0, 100);
    idle(2); tick();
    xfer(2, 1'b1, 12'h008, 32'h00005A5A, 4'hF, 32'd0, 2);
    idle(2); tick();

    xfer(0, 1'b1, 12'h000, 32'h11111111, 4'hF, 32'd0, 0);
    t1 = last_wr;
    xfer(0, 1'b1, 12'h004, 32'h22222222, 4'h3, 32'd0, 0);
    chk("b2b_gap", 64'(last_wr - t1), 64'd2);
    xfer(0, 1'b1, 12'h00C, 32'h33333333, 4'h0, 32'd0, 0);
    idle(0); tick();

    // access phase without a preceding setup must be ignored
    setup(0, 1'b1, 12'h010, 32'h1, 4'hF);
    penable[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_setup", 64'(obs(0)), 64'd0);
      tick();
    end
    idle(0); tick();

    // second setup inside ACCESS re-latches the transfer
    setup(1, 1'b1, 12'h041, 32'hBAD0BAD0, 4'hF);
    tick();
    xfer(1, 1'b1, 12'h020, 32'h600DF00D, 4'hC, 32'd0, 0);
    idle(1); tick();

    // abort mid-wait, then an unsetup access must not complete anything
    setup(3, 1'b1, 12'h010, 32'h77777777, 4'hF);
    tick();
    penable[3] = 1'b1;
    @(negedge clk);
    chk("abort_access", 64'(obs(3)), 64'd0);
    tick();
    idle(3);
    @(negedge clk);
    chk("abort_drop", 64'(obs(3)), 64'd0);
    tick();
    psel[3] = 1'b1;
    penable[3] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("abort_after", 64'(obs(3)), 64'd0);
      tick();
    end
    idle(3); tick();
    xfer(3, 1'b0, 12'h018, 32'd0, 4'hF, 32'h0BADCAFE, 0);
    idle(3); tick();

    // reset during a stalled transfer; busy released in the reset cycle
    setup(0, 1'b1, 12'h014, 32'h44444444, 4'hF);
    tick();
    penable[0] = 1'b1;
    reg_busy[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall", 64'(obs(0)), 64'd0);
      tick();
    end
    rst_n = 1'b0;
    reg_busy[0] = 1'b0;
    @(negedge clk);
    chk_all_zero("reset_mid");
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset_mid", 64'(obs(0)), 64'd0);
    chk("after_reset_addr", 64'(reg_addr[0]), 64'd0);
    tick();
    idle(0); tick();
    xfer(0, 1'b1, 12'h018, 32'h55555555, 4'h5, 32'd0, 0);
    idle(0); tick();

    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 25; n++) begin
        wr = 1'($urandom_range(0, 1));
        bn = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 8));
        xfer(k, wr, 12'($urandom_range(0, 'h4F)), $urandom, 4'($urandom_range(0, 15)), $urandom, bn);
        if ($urandom_range(0, 3) == 0) begin
          idle(k); tick();
        end
      end
      idle(k); tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
